mult_ctrl: RTL and testbench
============================

MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 Parameter N, default 4: multiplier width, equal to the number of add/shift iterations.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request to begin a multiplication; a level sampled at the clock edge.
REQ-005 q0  input  1  bit 0 of the datapath register (the current multiplier LSB).
REQ-006 LOAD  output  1  datapath load strobe: accumulator and carry cleared, multiplier loaded into the low N bits.
REQ-007 ADD  output  1  datapath strobe: {carry, sum} written into the upper N+1 register bits.
REQ-008 SHIFT  output  1  datapath strobe: whole 2N+1-bit register shifted right by one, zero in at MSB.
REQ-009 busy  output  1  high while a multiplication is in progress.
REQ-010 done  output  1  one-cycle pulse; the product in the register is valid from this cycle until the next LOAD.

Function
REQ-011 Moore FSM with states IDLE, LOAD, TEST, ADD, SHIFT, DONE; all outputs decoded from the registered state only.
REQ-012 Output decode: LOAD=1 only in LOAD; ADD=1 only in ADD; SHIFT=1 only in SHIFT; done=1 only in DONE; busy=1 in LOAD/TEST/ADD/SHIFT.
REQ-013 No two of LOAD, ADD and SHIFT are ever high in the same cycle.
REQ-014 IDLE: start=1 -> LOAD; else stay in IDLE.
REQ-015 LOAD -> TEST unconditionally; the iteration counter is cleared to 0.
REQ-016 TEST: q0=1 -> ADD; q0=0 -> SHIFT. The TEST state exists so that q0 reflects the register value after the preceding LOAD or SHIFT edge.
REQ-017 ADD -> SHIFT unconditionally.
REQ-018 SHIFT: if count==N-1 -> DONE; else count increments by 1 and the FSM goes to TEST.
REQ-019 The counter is $clog2(N) bits wide and never wraps during an operation; it is don't-care outside busy.
REQ-020 DONE: start=1 -> LOAD (back-to-back operation with no IDLE cycle); else -> IDLE.
REQ-021 start is ignored in every state except IDLE and DONE; no queuing of requests.
REQ-022 Latency from the edge sampling start to done high = 1 + 2N + popcount(multiplier) + 1 cycles (12 for N=4, multiplier 9).
REQ-023 q0 is ignored in all states except TEST.

Reset
REQ-024 reset=1 at a clock edge forces IDLE and count=0, regardless of the current state, including mid-operation and during DONE.
REQ-025 Output values during and after reset: LOAD=0, ADD=0, SHIFT=0, busy=0, done=0.
REQ-026 reset has priority over start in the same cycle.
REQ-027 The first edge with reset=0 evaluates start normally.

Structure
REQ-028 The state enum (ctrl_state_t) and the default width constant MULT_N=4 live in the shared package mult_pkg, which the datapath also imports.
REQ-029 Single flat module with no sub-modules; the counter is inline.
REQ-030 Integration into the top level (mult_top: mult_ctrl + adder + regs) is outside this block.

Verification
REQ-031 Multiplier 9, start pulsed 1 cycle -> observed strobe sequence LOAD,-,ADD,SHIFT,-,SHIFT,-,SHIFT,-,ADD,SHIFT then done, with done 12 cycles after start.
REQ-032 Multiplier 0 -> zero ADD pulses, exactly 4 SHIFT pulses, done 10 cycles after start; multiplier 15 -> 4 ADD pulses, 4 SHIFT pulses, done at 14 cycles.
REQ-033 With a behavioural datapath model, all 16x16 operand pairs are exercised -> register[7:0] equals a*b at done, for every pair.
REQ-034 start held high continuously -> back-to-back operations with DONE followed directly by LOAD, no IDLE cycle; start pulses during busy are ignored.
REQ-035 reset asserted in the ADD state of the second iteration -> next cycle all outputs are 0 and the state is IDLE; a following start runs a full, correct operation.
REQ-036 reset and start high in the same cycle -> stays in IDLE, LOAD not asserted.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: controller states, strobe bundle, sizes.
// Imported by the controller and by the datapath.
package mult_pkg;

  localparam int MULT_N     = 4;
  localparam int MULT_REG_W = 2 * MULT_N + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_DONE
  } ctrl_state_t;

  typedef struct packed {
    logic load;
    logic add;
    logic shift;
    logic busy;
    logic done;
  } ctrl_out_t;

  // Moore decode: the strobe bundle is a pure function of the state being entered.
  function automatic ctrl_out_t ctrl_decode(input ctrl_state_t s);
    ctrl_out_t o;
    o.load  = (s == S_LOAD);
    o.add   = (s == S_ADD);
    o.shift = (s == S_SHIFT);
    o.done  = (s == S_DONE);
    o.busy  = (s == S_LOAD) || (s == S_TEST) || (s == S_ADD) || (s == S_SHIFT);
    return o;
  endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Shift-add multiplier controller; done arrives 2 + 2N + popcount(multiplier) cycles after start.
// start is honoured only in IDLE or DONE (DONE allows back-to-back), never queued while busy.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  output logic LOAD,
  output logic ADD,
  output logic SHIFT,
  output logic busy,
  output logic done
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  ctrl_state_t   state;
  logic [CW-1:0] count;
  ctrl_out_t     out_q;

  // Outputs are registered together with the state they decode from, so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      out_q <= ctrl_decode(S_IDLE);
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            out_q <= ctrl_decode(S_LOAD);
          end
        end
        S_LOAD: begin
          count <= '0;
          state <= S_TEST;
          out_q <= ctrl_decode(S_TEST);
        end
        // q0 is only trusted here, one cycle after the LOAD or SHIFT edge has settled.
        S_TEST: begin
          if (q0) begin
            state <= S_ADD;
            out_q <= ctrl_decode(S_ADD);
          end else begin
            state <= S_SHIFT;
            out_q <= ctrl_decode(S_SHIFT);
          end
        end
        S_ADD: begin
          state <= S_SHIFT;
          out_q <= ctrl_decode(S_SHIFT);
        end
        S_SHIFT: begin
          if (count == LAST) begin
            state <= S_DONE;
            out_q <= ctrl_decode(S_DONE);
          end else begin
            count <= count + 1'b1;
            state <= S_TEST;
            out_q <= ctrl_decode(S_TEST);
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_LOAD;
            out_q <= ctrl_decode(S_LOAD);
          end else begin
            state <= S_IDLE;
            out_q <= ctrl_decode(S_IDLE);
          end
        end
        default: begin
          state <= S_IDLE;
          out_q <= ctrl_decode(S_IDLE);
        end
      endcase
    end
  end

  assign LOAD  = out_q.load;
  assign ADD   = out_q.add;
  assign SHIFT = out_q.shift;
  assign busy  = out_q.busy;
  assign done  = out_q.done;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl with a behavioural shift-add datapath and a done-driven scoreboard.
module tb_mult_ctrl;
  import mult_pkg::*;

  localparam int N  = MULT_N;
  localparam int RW = MULT_REG_W;

  typedef struct {
    int    prod;
    int    lat;
    int    adds;
    int    shifts;
    string trace;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic q0;
  logic LOAD, ADD, SHIFT, busy, done;

  logic [N-1:0]  a_in = '0;
  logic [N-1:0]  b_in = '0;
  logic [N-1:0]  mcand = '0;
  logic [RW-1:0] r = '0;
  logic          rst_d = 1'b1;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  mult_ctrl #(.N(N)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .q0   (q0),
    .LOAD (LOAD),
    .ADD  (ADD),
    .SHIFT(SHIFT),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Behavioural datapath reacting to the strobes.
  assign q0 = r[0];
  always @(posedge clk) begin
    rst_d <= reset;
    if (LOAD) begin
      r     <= {{(N + 1){1'b0}}, b_in};
      mcand <= a_in;
    end else if (ADD) begin
      r[RW-1:N] <= {1'b0, r[RW-2:N]} + {1'b0, mcand};
    end else if (SHIFT) begin
      r <= r >> 1;
    end
  end

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void chk_s(input string name, input string act, input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endfunction

  // Monitor: builds a per-operation strobe trace and pops the scoreboard on done.
  bit    in_op = 1'b0;
  int    cyc = 0;
  int    n_add = 0;
  int    n_shift = 0;
  string tr = "";
  always @(negedge clk) begin
    if (rst_d) begin
      chk("reset_outputs", int'({LOAD, ADD, SHIFT, busy, done}), 0);
      in_op = 1'b0;
    end else begin
      chk("strobe_onehot", ($countones({LOAD, ADD, SHIFT}) <= 1) ? 1 : 0, 1);
      if (LOAD) begin
        in_op = 1'b1;
        cyc = 1;
        tr = "L";
        n_add = 0;
        n_shift = 0;
      end else if (in_op) begin
        cyc++;
        if (!done) begin
          tr = {tr, ADD ? "A" : (SHIFT ? "S" : "-")};
          n_add += int'(ADD);
          n_shift += int'(SHIFT);
        end
      end
      if (done) begin
        if (!in_op) begin
          chk("done_stray", int'(done), 0);
        end else if (sb.size() == 0) begin
          chk("done_unexpected", int'(done), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc, e.lat);
          chk("product", int'(r[2*N-1:0]), e.prod);
          chk("add_count", n_add, e.adds);
          chk("shift_count", n_shift, e.shifts);
          if (e.trace != "") chk_s("trace", tr, e.trace);
        end
        in_op = 1'b0;
        chk("busy_at_done", int'(busy), 0);
      end else begin
        chk("busy", int'(busy), int'(in_op));
      end
    end
  end

  task automatic push(input int a, input int b, input int lat, input string trc);
    exp_t e;
    e.prod   = a * b;
    e.lat    = lat;
    e.adds   = $countones(b);
    e.shifts = N;
    e.trace  = trc;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", int'(done), 1);
  endtask

  // Called right after a negedge; returns at the negedge after done (controller idle).
  task automatic run_op(input int a, input int b, input int lat, input string trc);
    a_in  = N'(a);
    b_in  = N'(b);
    reset = 1'b0;
    start = 1'b1;
    push(a, b, lat, trc);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    int nadd;
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nadd;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'({LOAD, ADD, SHIFT, busy, done}), 0);

    // First edge after reset release takes start; hand-computed directed vectors.
    run_op(7, 9, 12, "L-AS-S-S-AS");
    chk("idle_after_op", int'(busy), 0);
    run_op(13, 0, 10, "L-S-S-S-S");
    run_op(15, 15, 14, "L-AS-AS-AS-AS");

    // start held high: DONE goes straight to LOAD.
    a_in = 4'd3; b_in = 4'd5; start = 1'b1;
    push(3, 5, 12, "L-AS-S-AS-S");
    wait_done();
    a_in = 4'd6; b_in = 4'd10;
    push(6, 10, 12, "L-S-AS-S-AS");
    @(negedge clk);
    chk("b2b_load_1", int'(LOAD), 1);
    wait_done();
    a_in = 4'd11; b_in = 4'd12;
    push(11, 12, 12, "L-S-S-AS-AS");
    @(negedge clk);
    chk("b2b_load_2", int'(LOAD), 1);
    start = 1'b0;
    wait_done();
    @(negedge clk);
    chk("b2b_idle", int'({LOAD, busy}), 0);

    // start pulses while busy are ignored.
    a_in = 4'd9; b_in = 4'd15; start = 1'b1;
    push(9, 15, 14, "L-AS-AS-AS-AS");
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done();
    @(negedge clk);
    chk("busy_pulse_no_reload", int'({LOAD, busy}), 0);

    // Reset in the ADD of the second iteration aborts the operation.
    a_in = 4'd5; b_in = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    nadd = 0;
    for (int i = 0; i < 30 && nadd < 2; i++) begin
      @(negedge clk);
      if (ADD) nadd++;
    end
    chk("second_add_seen", nadd, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", int'({LOAD, ADD, SHIFT, busy, done}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_stays_idle", int'({LOAD, busy}), 0);
    run_op(5, 3, 12, "L-AS-AS-S-S");

    // Reset and start together from IDLE: reset wins.
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_start_load", int'(LOAD), 0);
    chk("rst_start_busy", int'(busy), 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_after", int'({LOAD, busy}), 0);

    // Reset during DONE with start high: no reload.
    a_in = 4'd2; b_in = 4'd1; start = 1'b1;
    push(2, 1, 11, "L-AS-S-S-S");
    @(negedge clk); start = 1'b0;
    wait_done();
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_done_outputs", int'({LOAD, ADD, SHIFT, busy, done}), 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    // Full operand sweep against the datapath model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a, b, 2 + 2 * N + $countones(b), "");
      end
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
